cms_ctrl_arbiter: RTL and testbench
===================================

CMS_CTRL_ARBITER -- requirements
Module: cms_ctrl_arbiter

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 1, meaning cycles ctrl_write_enable is held high per write (legal 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, meaning minimum low cycles after each pulse before the next write (legal 1..255).
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_valid/req1_valid  in  1 each  requester write pending.
REQ-006 SHALL have ports req0_addr/req1_addr  in  8 each  target control address.
REQ-007 SHALL have ports req0_wdata/req1_wdata  in  64 each  target control data.
REQ-008 SHALL have ports req0_lock/req1_lock  in  1 each  keep grant for the requester's next write.
REQ-009 SHALL have ports req0_ready/req1_ready  out  1 each  write accepted this cycle.
REQ-010 SHALL have port ctrl_addr  out  8  address to monitoring-system control port.
REQ-011 SHALL have port ctrl_wdata  out  64  data to monitoring-system control port.
REQ-012 SHALL have port ctrl_write_enable  out  1  write strobe, safe for posedge- and level-triggered targets.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port last_grant  out  1  index of the most recently accepted requester.
REQ-015 SHALL have port write_count  out  32  number of completed pulses, wraps modulo 2^32.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, PULSE, GAP.
REQ-017 In IDLE, reqN_ready SHALL be combinational and high only for the winner; acceptance is valid&ready at a rising edge.
REQ-018 Arbitration SHALL be round-robin: with both requesters valid, the grant goes to the requester that is not last_grant.
REQ-019 Locking SHALL override round-robin: if the last accepted write had lock=1 and that requester is valid, it wins again; a lock with the requester not valid in IDLE SHALL be released.
REQ-020 On acceptance, ctrl_addr/ctrl_wdata SHALL load the winner's addr/wdata, last_grant SHALL update, and the FSM SHALL go to SETUP.
REQ-021 SETUP SHALL last exactly 1 cycle with ctrl_write_enable=0 (address/data setup), then go to PULSE.
REQ-022 PULSE SHALL last exactly PULSE_CYCLES cycles with ctrl_write_enable=1; write_count SHALL increment on PULSE exit.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles with ctrl_write_enable=0, then go to IDLE.
REQ-024 ctrl_addr/ctrl_wdata SHALL hold stable from acceptance until the next acceptance.
REQ-025 Accept-to-accept minimum period SHALL be 2+PULSE_CYCLES+GAP_CYCLES cycles; reqN_ready SHALL be 0 outside IDLE.
REQ-026 ctrl_write_enable SHALL be driven directly from a register (glitch-free).
REQ-027 Requests changing while not ready SHALL have no effect; a requester is never dropped (no starvation beyond one lock sequence).

Reset
REQ-028 On rst assertion, the FSM SHALL enter IDLE immediately, including mid-PULSE, forcing ctrl_write_enable=0 without waiting for a clock edge.
REQ-029 Reset values: ctrl_addr=0, ctrl_wdata=0, ctrl_write_enable=0, busy=0, last_grant=1 (requester 0 wins first), write_count=0, lock state cleared; a pulse cut short by reset SHALL not be counted.

Structure
REQ-030 FSM state encoding, CTRL_ADDR_WIDTH=8 and CTRL_DATA_WIDTH=64 SHALL reside in the shared package cms_pkg.
REQ-031 A single sub-module cms_cycle_timer (loadable 8-bit down-counter with done flag) SHALL time both PULSE and GAP.

Verification
REQ-032 Single write: req0 addr=2 wdata=0x8000_0000 at cycle 0 -> ready0 at cycle 0, ctrl_addr=2 at cycle 1, write_enable high cycle 2 only, busy low at cycle 4, write_count=1.
REQ-033 Contention: both valid continuously, no lock -> grants alternate 0,1,0,1, each accept 4 cycles apart with defaults.
REQ-034 Lock: req1 issues addr=6 then addr=4 with lock=1 on the first while req0 valid -> both req1 writes precede req0's write.
REQ-035 Parameters PULSE_CYCLES=3, GAP_CYCLES=2 -> write_enable high exactly 3 cycles, low ≥3 cycles (SETUP+GAP) between pulses.
REQ-036 Reset asserted mid-PULSE (asynchronous, between edges) -> write_enable falls immediately, write_count unchanged, next accepted request goes to requester 0.
REQ-037 write_count preloaded to 0xFFFF_FFFF via force, one write -> write_count=0.

Source files
------------

// File: rtl/cms_pkg.sv
// Shared types and widths for the monitoring-system control-port arbiter.
package cms_pkg;

    localparam int CTRL_ADDR_WIDTH = 8;
    localparam int CTRL_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } cms_state_e;

    // A phase of n cycles is timed by loading n-1 and waiting for zero.
    function automatic logic [7:0] cycles_to_load(input int unsigned n);
        return 8'(n - 1);
    endfunction

endpackage

// File: rtl/cms_cycle_timer.sv
// Loadable 8-bit down-counter; done is high while the count sits at zero.
module cms_cycle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       done_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 8'd0);

endmodule

// File: rtl/cms_ctrl_arbiter.sv
// Two-requester round-robin arbiter with lock, driving a timed write strobe
// (setup, pulse, gap) onto the monitoring-system control port.
module cms_ctrl_arbiter
    import cms_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    input  logic                       req1_valid,
    input  logic [CTRL_ADDR_WIDTH-1:0] req0_addr,
    input  logic [CTRL_ADDR_WIDTH-1:0] req1_addr,
    input  logic [CTRL_DATA_WIDTH-1:0] req0_wdata,
    input  logic [CTRL_DATA_WIDTH-1:0] req1_wdata,
    input  logic                       req0_lock,
    input  logic                       req1_lock,
    output logic                       req0_ready,
    output logic                       req1_ready,
    output logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
    output logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
    output logic                       ctrl_write_enable,
    output logic                       busy,
    output logic                       last_grant,
    output logic [31:0]                write_count
);

    localparam logic [7:0] PULSE_LOAD = cycles_to_load(PULSE_CYCLES);
    localparam logic [7:0] GAP_LOAD   = cycles_to_load(GAP_CYCLES);

    cms_state_e                 state_q, state_d;
    logic [CTRL_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CTRL_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                       we_q, we_d;
    logic                       last_q, last_d;
    logic                       lock_q, lock_d;
    logic [31:0]                write_count_q, write_count_d;

    logic       winner;
    logic       accept;
    logic       timer_load;
    logic [7:0] timer_val;
    logic       timer_done;

    cms_cycle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .done_o     (timer_done)
    );

    // A held lock only matters while its owner is still asking.
    always_comb begin
        if (lock_q && (last_q ? req1_valid : req0_valid)) begin
            winner = last_q;
        end else if (req0_valid && req1_valid) begin
            winner = ~last_q;
        end else begin
            winner = req1_valid;
        end
    end

    assign accept     = (state_q == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !winner;
    assign req1_ready = accept && winner;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        last_d        = last_q;
        lock_d        = lock_q;
        write_count_d = write_count_q;
        timer_load    = 1'b0;
        timer_val     = PULSE_LOAD;
        case (state_q)
            ST_IDLE: begin
                lock_d = 1'b0;
                if (accept) begin
                    state_d = ST_SETUP;
                    addr_d  = winner ? req1_addr  : req0_addr;
                    wdata_d = winner ? req1_wdata : req0_wdata;
                    last_d  = winner;
                    lock_d  = winner ? req1_lock  : req0_lock;
                end
            end
            ST_SETUP: begin
                state_d    = ST_PULSE;
                timer_load = 1'b1;
                timer_val  = PULSE_LOAD;
            end
            ST_PULSE: begin
                if (timer_done) begin
                    state_d       = ST_GAP;
                    timer_load    = 1'b1;
                    timer_val     = GAP_LOAD;
                    write_count_d = write_count_q + 32'd1;
                end
            end
            ST_GAP: begin
                if (timer_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        we_d = (state_d == ST_PULSE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            last_q        <= 1'b1;
            lock_q        <= 1'b0;
            write_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            last_q        <= last_d;
            lock_q        <= lock_d;
            write_count_q <= write_count_d;
        end
    end

    assign ctrl_addr         = addr_q;
    assign ctrl_wdata        = wdata_q;
    assign ctrl_write_enable = we_q;
    assign busy              = (state_q != ST_IDLE);
    assign last_grant        = last_q;
    assign write_count       = write_count_q;

endmodule

// File: tb/tb_cms_ctrl_arbiter.sv
// Self-checking bench: directed vector table, reset/wrap sequences, and
// randomized traffic against a timestamp-based reference model.
module tb_cms_ctrl_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_lock, req1_lock;
    logic [7:0]  req0_addr, req1_addr;
    logic [63:0] req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready, ctrl_write_enable, busy, last_grant;
    logic [7:0]  ctrl_addr;
    logic [63:0] ctrl_wdata;
    logic [31:0] write_count;

    logic        b_valid;
    logic        b_ready0, b_ready1, b_we, b_busy, b_last;
    logic [7:0]  b_addr;
    logic [63:0] b_wdata;
    logic [31:0] b_count;

    int vectors     = 0;
    int miscompares = 0;
    int exp_wc      = 0;

    always #5 clk = ~clk;

    cms_ctrl_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_lock(req0_lock), .req1_lock(req1_lock),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_write_enable(ctrl_write_enable), .busy(busy),
        .last_grant(last_grant), .write_count(write_count)
    );

    cms_ctrl_arbiter #(.PULSE_CYCLES(3), .GAP_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req0_valid(b_valid), .req1_valid(1'b0),
        .req0_addr(8'h05), .req1_addr(8'h00),
        .req0_wdata(64'h1), .req1_wdata(64'h0),
        .req0_lock(1'b0), .req1_lock(1'b0),
        .req0_ready(b_ready0), .req1_ready(b_ready1),
        .ctrl_addr(b_addr), .ctrl_wdata(b_wdata),
        .ctrl_write_enable(b_we), .busy(b_busy),
        .last_grant(b_last), .write_count(b_count)
    );

    typedef struct {
        logic        v0, v1, lk0, lk1;
        logic [7:0]  a0, a1;
        logic [63:0] d0, d1;
        logic        er0, er1;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic v1, input logic lk0, input logic lk1,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1);
        req0_valid = v0; req1_valid = v1; req0_lock = lk0; req1_lock = lk1;
        req0_addr = a0; req1_addr = a1; req0_wdata = d0; req1_wdata = d1;
    endtask

    // One idle-cycle row; an accepted write is followed through SETUP/PULSE/GAP
    // with the same inputs held, so the next row lands exactly 4 cycles later.
    task automatic apply_row(input vec_t r, input int idx);
        logic        acc;
        logic [7:0]  ea;
        logic [63:0] ed;
        @(negedge clk);
        drive(r.v0, r.v1, r.lk0, r.lk1, r.a0, r.a1, r.d0, r.d1);
        #1;
        chk("row_ready0", req0_ready, r.er0);
        chk("row_ready1", req1_ready, r.er1);
        chk("row_busy_idle", busy, 0);
        acc = r.er0 | r.er1;
        ea  = r.er1 ? r.a1 : r.a0;
        ed  = r.er1 ? r.d1 : r.d0;
        $display("row %0d: ready0=%0b ready1=%0b", idx, req0_ready, req1_ready);
        @(posedge clk);
        if (acc) begin
            exp_wc++;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                #1;
                chk("row_noready0", req0_ready, 0);
                chk("row_noready1", req1_ready, 0);
                chk("row_busy", busy, 1);
                chk("row_addr", ctrl_addr, ea);
                chk("row_wdata", ctrl_wdata, ed);
                chk("row_we", ctrl_write_enable, (k == 2));
                chk("row_last_grant", last_grant, r.er1);
            end
            chk("row_write_count", write_count, exp_wc);
        end
    endtask

    task automatic do_write(input logic sel, input logic [7:0] a, input logic [63:0] d);
        @(negedge clk);
        drive(!sel, sel, 0, 0, a, a, d, d);
        #1;
        chk("wr_ready", sel ? req1_ready : req0_ready, 1);
        @(posedge clk);
        exp_wc++;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        $display("write sel=%0b addr=%0h count=%0h", sel, a, write_count);
    endtask

    // Reference model state: timestamps of the last acceptance, not FSM states.
    int          cyc, acc_cyc, free_cyc;
    logic        m_last, m_lock;
    logic [7:0]  m_addr;
    logic [63:0] m_data;
    int          m_wc;

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 8'h02, 8'h00, 64'h8000_0000, 64'h0, 1, 0};
        tbl[1]  = '{1, 1, 0, 0, 8'h10, 8'h11, 64'hA0, 64'hA1, 0, 1};
        tbl[2]  = '{1, 1, 0, 0, 8'h12, 8'h13, 64'hB0, 64'hB1, 1, 0};
        tbl[3]  = '{1, 1, 0, 0, 8'h14, 8'h15, 64'hC0, 64'hC1, 0, 1};
        tbl[4]  = '{1, 1, 0, 0, 8'h16, 8'h17, 64'hD0, 64'hD1, 1, 0};
        tbl[5]  = '{1, 1, 0, 1, 8'h20, 8'h06, 64'hE0, 64'hE1, 0, 1};
        tbl[6]  = '{1, 1, 0, 0, 8'h20, 8'h04, 64'hE0, 64'hF1, 0, 1};
        tbl[7]  = '{1, 1, 0, 0, 8'h20, 8'h21, 64'hE0, 64'h11, 1, 0};
        tbl[8]  = '{1, 0, 1, 0, 8'h30, 8'h00, 64'h30, 64'h0, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 8'h00, 8'h00, 64'h0, 64'h0, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 8'h40, 8'h41, 64'h40, 64'h41, 0, 1};

        rst = 1'b1;
        b_valid = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_we", ctrl_write_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last_grant", last_grant, 1);
        chk("rst_write_count", write_count, 0);
        chk("rst_addr", ctrl_addr, 0);
        chk("rst_wdata", ctrl_wdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) apply_row(tbl[i], i);

        // Asynchronous reset in the middle of a pulse.
        @(negedge clk);
        drive(1, 0, 0, 0, 8'h33, 8'h00, 64'h33, 64'h0);
        #1;
        chk("mid_ready0", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("mid_we_high", ctrl_write_enable, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_we_async_low", ctrl_write_enable, 0);
        chk("mid_busy", busy, 0);
        chk("mid_write_count", write_count, 0);
        chk("mid_last_grant", last_grant, 1);
        exp_wc = 0;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 0, 0, 8'h50, 8'h51, 64'h50, 64'h51);
        #1;
        chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        @(posedge clk);
        exp_wc++;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("post_rst_count", write_count, exp_wc);

        // write_count wraps.
        force u_dut.write_count_q = 32'hFFFF_FFFF;
        #1;
        release u_dut.write_count_q;
        do_write(1, 8'h60, 64'h60);
        chk("wrap_count", write_count, 0);

        // Longer pulse/gap instance: 3 high, 4 low (gap 2 + idle + setup).
        begin
            int  hi_run, lo_run, seen_rise;
            logic prev;
            hi_run = 0; lo_run = 0; seen_rise = 0; prev = 1'b0;
            @(negedge clk);
            b_valid = 1'b1;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                #1;
                if (b_we) begin
                    if (!prev && seen_rise > 0) chk("p3_low_run", lo_run, 4);
                    if (!prev) begin seen_rise++; hi_run = 0; end
                    hi_run++;
                end else begin
                    if (prev) begin chk("p3_high_run", hi_run, 3); lo_run = 0; end
                    lo_run++;
                end
                prev = b_we;
            end
            chk("p3_pulses_seen", (seen_rise >= 5), 1);
            b_valid = 1'b0;
        end

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0; acc_cyc = -100; free_cyc = 0;
        m_last = 1'b1; m_lock = 1'b0; m_addr = 0; m_data = 0; m_wc = 0;
        for (int n = 0; n < 500; n++) begin
            logic v0, v1, l0, l1, idle, anyv, w;
            @(negedge clk);
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            l0 = ($urandom_range(0, 3) == 0);
            l1 = ($urandom_range(0, 3) == 0);
            drive(v0, v1, l0, l1, 8'($urandom), 8'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom});
            #1;
            idle = (cyc >= free_cyc);
            anyv = v0 | v1;
            if (m_lock && (m_last ? v1 : v0)) w = m_last;
            else if (v0 && v1)               w = !m_last;
            else                             w = v1;
            chk("rnd_ready0", req0_ready, idle && anyv && !w);
            chk("rnd_ready1", req1_ready, idle && anyv && w);
            chk("rnd_busy", busy, !idle);
            chk("rnd_we", ctrl_write_enable, (cyc == acc_cyc + 2));
            chk("rnd_addr", ctrl_addr, m_addr);
            chk("rnd_wdata", ctrl_wdata, m_data);
            chk("rnd_last_grant", last_grant, m_last);
            chk("rnd_write_count", write_count, m_wc);
            @(posedge clk);
            if (cyc == acc_cyc + 2) m_wc++;
            if (idle) begin
                if (anyv) begin
                    acc_cyc  = cyc;
                    free_cyc = cyc + 4;
                    m_last   = w;
                    m_lock   = w ? l1 : l0;
                    m_addr   = w ? req1_addr : req0_addr;
                    m_data   = w ? req1_wdata : req0_wdata;
                end else begin
                    m_lock = 1'b0;
                end
            end
            cyc++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
